// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the digit-serial limb multiplier.
package mult_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DIGIT_W_MIN = 1;
    localparam int DIGIT_W_MAX = 16;

    // Number of compute steps needed to consume b_w multiplier bits.
    function automatic int nstep(input int b_w, input int digit_w);
        return (b_w + digit_w - 1) / digit_w;
    endfunction

    function automatic bit digit_w_legal(input int digit_w);
        return (digit_w >= DIGIT_W_MIN) && (digit_w <= DIGIT_W_MAX);
    endfunction

endpackage

// File: rtl/mult_digit_pp.sv
// Combinational A_W x DIGIT_W unsigned partial product; the parent shifts and accumulates.
module mult_digit_pp
    import mult_pkg::*;
#(
    parameter int A_W     = 130,
    parameter int DIGIT_W = 4
)
(
    input  logic [A_W-1:0]         a,
    input  logic [DIGIT_W-1:0]     digit,
    output logic [A_W+DIGIT_W-1:0] pp
);

    assign pp = (A_W+DIGIT_W)'(a) * (A_W+DIGIT_W)'(digit);

endmodule

// File: rtl/mult_radix_limb.sv
// Multi-cycle unsigned multiplier consuming DIGIT_W multiplier bits per cycle, tag carried alongside.
// Optional MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mult_radix_limb
    import mult_pkg::*;
#(
    parameter int A_W     = 130,
    parameter int B_W     = 128,
    parameter int DIGIT_W = 4,
    parameter int TAG_W   = 4
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [A_W-1:0]       a_in,
    input  logic [B_W-1:0]       b_in,
    input  logic [TAG_W-1:0]     tag_in,
    output logic [A_W+B_W-1:0]   product_out,
    output logic [TAG_W-1:0]     tag_out,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           cycles_out
);

    localparam int NSTEP   = nstep(B_W, DIGIT_W);
    localparam int BPAD_W  = NSTEP * DIGIT_W;
    localparam int P_W     = A_W + B_W;
    localparam int ACC_EXT = A_W + BPAD_W;
    localparam int CNT_W   = $clog2(NSTEP + 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(NSTEP - 1);

    if (!digit_w_legal(DIGIT_W)) begin : g_bad_digit_w
        $error("mult_radix_limb: DIGIT_W must be within 1..16");
    end

    state_t               state;
    state_t               state_nxt;
    logic [A_W-1:0]       a_reg;
    logic [BPAD_W-1:0]    b_reg;
    logic [BPAD_W-1:0]    b_shift;
    logic [TAG_W-1:0]     tag_reg;
    logic [P_W-1:0]       acc;
    logic [P_W-1:0]       acc_sum;
    logic [P_W-1:0]       pp_sh;
    logic [A_W+DIGIT_W-1:0] pp;
    logic [CNT_W-1:0]     step;
    logic [CNT_W-1:0]     step_inc;
    logic                 last_step;
    logic                 accept;
    logic                 fin;

    mult_digit_pp #(
        .A_W     (A_W),
        .DIGIT_W (DIGIT_W)
    ) u_pp (
        .a     (a_reg),
        .digit (b_reg[DIGIT_W-1:0]),
        .pp    (pp)
    );

    // The true product fits in P_W bits, so the shifted partial product is truncated there.
    assign pp_sh    = P_W'(ACC_EXT'(pp) << (32'(step) * DIGIT_W));
    assign acc_sum  = acc + pp_sh;
    assign b_shift  = b_reg >> DIGIT_W;
    assign step_inc = step + 1'b1;

`ifdef MULT_EARLY_EXIT_EN
    assign last_step = (step == STEP_LAST) || (b_shift == '0);
`else
    assign last_step = (step == STEP_LAST);
`endif

    assign busy = (state == RUN);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            tag_reg     <= '0;
            acc         <= '0;
            step        <= '0;
            product_out <= '0;
            tag_out     <= '0;
            cycles_out  <= '0;
            done        <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= fin;
            if (accept) begin
                a_reg   <= a_in;
                b_reg   <= BPAD_W'(b_in);
                tag_reg <= tag_in;
                acc     <= '0;
                step    <= '0;
            end else if (state == RUN) begin
                acc   <= acc_sum;
                b_reg <= b_shift;
                step  <= step_inc;
            end
            // Result registers only change on completion so callers can read them any time.
            if (fin) begin
                product_out <= acc_sum;
                tag_out     <= tag_reg;
                cycles_out  <= 8'(step_inc);
            end
        end
    end

endmodule

// File: tb/tb_mult_radix_limb.sv
// Bench for mult_radix_limb: default instance (DIGIT_W=4) and a DIGIT_W=3 instance, scoreboard-checked.
module tb_mult_radix_limb;

`ifdef MULT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [257:0] p;
        logic [3:0]   tag;
        logic [7:0]   cyc;
        int           due;
    } exp_t;

    typedef struct {
        logic [129:0] a;
        logic [127:0] b;
        logic [3:0]   tag;
        logic [257:0] p;
        logic [7:0]   cyc_ee;
        logic [7:0]   cyc_full;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    logic         start0, start3;
    logic [129:0] a0, a3;
    logic [127:0] b0, b3;
    logic [3:0]   tag0, tag3;
    logic [257:0] prod0, prod3;
    logic [3:0]   tago0, tago3;
    logic         busy0, busy3, done0, done3;
    logic [7:0]   cyco0, cyco3;

    exp_t         q0[$];
    exp_t         q3[$];
    exp_t         m0, m3;
    logic [257:0] hold0 = '0;
    logic [257:0] hold3 = '0;
    vec_t         tbl[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_radix_limb dut0 (
        .clk(clk), .reset(reset), .start(start0), .a_in(a0), .b_in(b0), .tag_in(tag0),
        .product_out(prod0), .tag_out(tago0), .busy(busy0), .done(done0), .cycles_out(cyco0)
    );

    mult_radix_limb #(.A_W(130), .B_W(128), .DIGIT_W(3), .TAG_W(4)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .a_in(a3), .b_in(b3), .tag_in(tag3),
        .product_out(prod3), .tag_out(tago3), .busy(busy3), .done(done3), .cycles_out(cyco3)
    );

    function automatic void chk(input string name, input logic [257:0] act, input logic [257:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    function automatic logic [257:0] mul(input logic [129:0] a, input logic [127:0] b);
        logic [257:0] wa, wb;
        wa = 258'(a);
        wb = 258'(b);
        return wa * wb;
    endfunction

    function automatic logic [7:0] exp_cyc(input logic [127:0] b, input int dw, input int ns);
        int n;
        n = ns;
        if (EARLY) begin
            n = 1;
            for (int i = 1; i < ns; i++)
                if ((b >> (i * dw)) != 128'd0) n = i + 1;
        end
        return 8'(n);
    endfunction

    // Scoreboard monitors: every cycle either no result is due (done must be low),
    // the head entry completes, or it is overdue.
    always @(negedge clk) begin
        if (!reset) begin
            if (q0.size() == 0) begin
                chk("done0_unexpected", 258'(done0), 258'(0));
            end else if (done0) begin
                m0 = q0.pop_front();
                chk("product0", prod0, m0.p);
                chk("tag0", 258'(tago0), 258'(m0.tag));
                chk("cycles0", 258'(cyco0), 258'(m0.cyc));
                chk("latency0", 258'(cyc), 258'(m0.due));
                hold0 = m0.p;
            end else if (cyc > q0[0].due) begin
                chk("done0_timeout", 258'(done0), 258'(1));
                void'(q0.pop_front());
            end
            if (!done0) chk("hold0", prod0, hold0);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (q3.size() == 0) begin
                chk("done3_unexpected", 258'(done3), 258'(0));
            end else if (done3) begin
                m3 = q3.pop_front();
                chk("product3", prod3, m3.p);
                chk("tag3", 258'(tago3), 258'(m3.tag));
                chk("cycles3", 258'(cyco3), 258'(m3.cyc));
                chk("latency3", 258'(cyc), 258'(m3.due));
                hold3 = m3.p;
            end else if (cyc > q3[0].due) begin
                chk("done3_timeout", 258'(done3), 258'(1));
                void'(q3.pop_front());
            end
            if (!done3) chk("hold3", prod3, hold3);
        end
    end

    task automatic issue0(input logic [129:0] a, input logic [127:0] b, input logic [3:0] t,
                          input logic [257:0] p, input logic [7:0] c);
        exp_t e;
        logic ok;
        @(negedge clk);
        ok = !busy0;
        start0 = 1'b1; a0 = a; b0 = b; tag0 = t;
        @(negedge clk);
        start0 = 1'b0; a0 = ~a; b0 = ~b; tag0 = ~t;
        chk("accept0", 258'(ok), 258'(1));
        if (ok) begin
            e.p = p; e.tag = t; e.cyc = c; e.due = cyc + int'(c);
            q0.push_back(e);
        end
    endtask

    task automatic issue3(input logic [129:0] a, input logic [127:0] b, input logic [3:0] t);
        exp_t e;
        logic ok;
        @(negedge clk);
        ok = !busy3;
        start3 = 1'b1; a3 = a; b3 = b; tag3 = t;
        @(negedge clk);
        start3 = 1'b0; a3 = ~a; b3 = ~b; tag3 = ~t;
        chk("accept3", 258'(ok), 258'(1));
        if (ok) begin
            e.p = mul(a, b); e.tag = t; e.cyc = exp_cyc(b, 3, 43); e.due = cyc + int'(e.cyc);
            q3.push_back(e);
        end
    endtask

    task automatic wait_idle0(input int limit);
        int n = 0;
        while ((q0.size() != 0 || busy0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) chk("idle0_timeout", 258'(busy0), 258'(0));
    endtask

    task automatic wait_idle3(input int limit);
        int n = 0;
        while ((q3.size() != 0 || busy3) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) chk("idle3_timeout", 258'(busy3), 258'(0));
    endtask

    // start held high with alternating operands: only idle-cycle requests are accepted.
    task automatic held0(input int ncyc);
        logic [129:0] ha[2];
        logic [127:0] hb[2];
        exp_t e;
        logic pend = 1'b0;
        int   n_acc = 0;
        ha[0] = {130{1'b1}} - 130'd4;
        hb[0] = {128{1'b1}};
        ha[1] = 130'h1_0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
        hb[1] = (128'd1 << 127) | 128'd12345;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (pend) begin
                e.due = cyc + int'(e.cyc);
                q0.push_back(e);
            end
            pend = !busy0;
            if (pend) n_acc++;
            start0 = 1'b1; a0 = ha[i % 2]; b0 = hb[i % 2]; tag0 = 4'(3 + i % 2);
            e.p = mul(a0, b0); e.tag = tag0; e.cyc = exp_cyc(b0, 4, 32);
        end
        @(negedge clk);
        if (pend) begin
            e.due = cyc + int'(e.cyc);
            q0.push_back(e);
        end
        start0 = 1'b0;
        chk("held_accepts", 258'(n_acc), 258'((ncyc + 32) / 33));
    endtask

    initial begin
        logic [129:0] a_max, p1305, a_mix, ra;
        logic [127:0] b_max, rb;
        logic [257:0] p_big;

        reset = 1'b1;
        start0 = 1'b0; a0 = '0; b0 = '0; tag0 = '0;
        start3 = 1'b0; a3 = '0; b3 = '0; tag3 = '0;

        a_max = {130{1'b1}};
        p1305 = a_max - 130'd4;
        b_max = {128{1'b1}};
        a_mix = 130'h2_DEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98;
        p_big = '0;
        p_big = p_big - (258'd1 << 130) - (258'd5 << 128) + 258'd5;

        tbl[0] = '{a: p1305, b: b_max, tag: 4'h5, p: p_big, cyc_ee: 8'd32, cyc_full: 8'd32};
        tbl[1] = '{a: 130'd0, b: b_max, tag: 4'h1, p: 258'd0, cyc_ee: 8'd32, cyc_full: 8'd32};
        tbl[2] = '{a: 130'd1, b: 128'd1, tag: 4'h2, p: 258'd1, cyc_ee: 8'd1, cyc_full: 8'd32};
        tbl[3] = '{a: a_mix, b: 128'd5, tag: 4'hA, p: 258'(a_mix) + (258'(a_mix) << 2),
                   cyc_ee: 8'd1, cyc_full: 8'd32};
        tbl[4] = '{a: a_mix, b: 128'd0, tag: 4'hB, p: 258'd0, cyc_ee: 8'd1, cyc_full: 8'd32};
        tbl[5] = '{a: a_max, b: 128'd1 << 127, tag: 4'hF, p: 258'(a_max) << 127,
                   cyc_ee: 8'd32, cyc_full: 8'd32};

        #3;
        chk("rst_busy", 258'(busy0), 258'(0));
        chk("rst_done", 258'(done0), 258'(0));
        chk("rst_product", prod0, 258'(0));
        chk("rst_tag", 258'(tago0), 258'(0));
        chk("rst_cycles", 258'(cyco0), 258'(0));
        chk("rst_busy3", 258'(busy3), 258'(0));
        @(negedge clk);
        #2 reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            issue0(tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].p, EARLY ? tbl[i].cyc_ee : tbl[i].cyc_full);
            wait_idle0(100);
        end

        held0(100);
        wait_idle0(100);

        issue0(a_mix, b_max, 4'h9, mul(a_mix, b_max), exp_cyc(b_max, 4, 32));
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", 258'(busy0), 258'(0));
        chk("midrst_product", prod0, 258'(0));
        chk("midrst_done", 258'(done0), 258'(0));
        chk("midrst_tag", 258'(tago0), 258'(0));
        chk("midrst_cycles", 258'(cyco0), 258'(0));
        q0.delete();
        hold0 = '0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        repeat (40) @(negedge clk);
        issue0(p1305, 128'd7, 4'h6, mul(p1305, 128'd7), exp_cyc(128'd7, 4, 32));
        wait_idle0(100);

        for (int i = 0; i < 1000; i++) begin
            ra = {2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) rb = b_max;
            else if (i % 4 == 3) rb = rb >> $urandom_range(0, 127);
            issue3(ra, rb, 4'(i));
            wait_idle3(100);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
